// File: rtl/pc_fetch_ctrl.sv
// Fetch-side controller: reads the PC, fetches over a req/ack memory handshake,
// buffers the instruction for decode and drives the PC register's write port.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_ena,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        exc_valid
);

   if ((RESET_VECTOR[1:0] != 2'b00) || (EXC_VECTOR[1:0] != 2'b00)) begin : g_bad_vector
      $error("pc_fetch_ctrl: RESET_VECTOR and EXC_VECTOR must be word aligned");
   end

   typedef enum logic [1:0] {SYNC, FETCH, HOLD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        pc_ena_q, pc_ena_d;
   logic [31:0] pc_next_q, pc_next_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_out_q, inst_out_d;
   logic [31:0] inst_pc_q, inst_pc_d;

   logic        flush;
   logic [31:0] flush_target;

   // Exception outranks a same-cycle redirect.
   assign flush        = exc_valid | redirect_valid;
   assign flush_target = exc_valid ? EXC_VECTOR : redirect_target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SYNC;
         pc_ena_q     <= 1'b0;
         pc_next_q    <= '0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
         inst_valid_q <= 1'b0;
         inst_out_q   <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_ena_q     <= pc_ena_d;
         pc_next_q    <= pc_next_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_out_q   <= inst_out_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   // An outstanding memory request is always completed (DRAIN) before refetching.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC: begin
            if (!flush) state_d = FETCH;
         end
         FETCH: begin
            if (flush)         state_d = imem_ack ? SYNC : DRAIN;
            else if (imem_ack) state_d = HOLD;
         end
         HOLD: begin
            if (flush)           state_d = SYNC;
            else if (inst_ready) state_d = FETCH;
         end
         DRAIN: begin
            if (imem_ack) state_d = SYNC;
         end
         default: state_d = SYNC;
      endcase
   end

   always_comb begin
      pc_ena_d     = 1'b0;
      pc_next_d    = pc_next_q;
      imem_addr_d  = imem_addr_q;
      inst_valid_d = inst_valid_q;
      inst_out_d   = inst_out_q;
      inst_pc_d    = inst_pc_q;
      imem_req_d   = (state_d == FETCH) || (state_d == DRAIN);

      // Entering FETCH samples the PC, which has settled after any earlier pulse.
      if ((state_d == FETCH) && (state_q != FETCH)) imem_addr_d = pc_in;

      if ((state_q == HOLD) && inst_ready) inst_valid_d = 1'b0;

      if ((state_q == FETCH) && imem_ack && !flush) begin
         inst_out_d   = imem_rdata;
         inst_pc_d    = imem_addr_q;
         inst_valid_d = 1'b1;
         pc_ena_d     = 1'b1;
         pc_next_d    = imem_addr_q + 32'd4;
      end

      if (flush) begin
         pc_ena_d     = 1'b1;
         pc_next_d    = flush_target;
         inst_valid_d = 1'b0;
      end
   end

   assign pc_ena     = pc_ena_q;
   assign pc_next    = pc_next_q;
   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign inst_valid = inst_valid_q;
   assign inst_out   = inst_out_q;
   assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: models the PC register and instruction memory,
// predicts the delivered instruction stream from redirects and sequential PC+4 flow.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'h0000_0004;

   localparam int COND_REQ_NOACK = 0;
   localparam int COND_VALID     = 1;
   localparam int COND_REQ_ACK   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in = RESET_VECTOR;
   logic        pc_ena;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        exc_valid = 1'b0;

   int checks = 0;
   int errors = 0;
   int mem_lat = 0;

   logic [31:0] exp_q[$];

   pc_fetch_ctrl #(.RESET_VECTOR(RESET_VECTOR), .EXC_VECTOR(EXC_VECTOR)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ena(pc_ena), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target), .exc_valid(exc_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // PC register: written on the negedge following a pc_ena pulse.
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         if (rst) pc_in = RESET_VECTOR;
         else if (pc_ena) pc_in = pc_next;
      end
   end

   // Instruction memory: acks after a per-request latency of 0..3 extra cycles.
   initial begin
      int  wait_cnt;
      bit  busy;
      wait_cnt = 0;
      busy     = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !imem_req || imem_ack) begin
            imem_ack = 1'b0;
            busy     = 0;
         end else begin
            if (!busy) begin
               busy     = 1;
               wait_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (wait_cnt == 0) imem_ack = 1'b1;
            else wait_cnt--;
         end
         imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      end
   end

   // Monitor: samples at negedge, pops the scoreboard on every decode transfer.
   initial begin
      logic        prev_valid, prev_ready, prev_flush, prev_req, prev_ack;
      logic [31:0] prev_target, prev_addr, prev_ipc, prev_iout, exp_pc, tgt_now;
      logic        flush_now;
      int          idle_cycles;
      prev_valid = 0; prev_ready = 0; prev_flush = 0; prev_req = 0; prev_ack = 0;
      prev_target = '0; prev_addr = '0; prev_ipc = '0; prev_iout = '0;
      idle_cycles = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 0; prev_ready = 0; prev_flush = 0; prev_req = 0; prev_ack = 0;
            idle_cycles = 0;
         end else begin
            flush_now = redirect_valid || exc_valid;
            tgt_now   = exc_valid ? EXC_VECTOR : redirect_target;
            checkOutput("pc_ena_pulse", 32'(pc_ena), 32'(prev_flush || (inst_valid && !prev_valid)));
            if (prev_flush) begin
               checkOutput("pc_next_redirect", pc_next, prev_target);
               checkOutput("valid_after_flush", 32'(inst_valid), 32'd0);
            end else if (inst_valid && !prev_valid && exp_q.size() > 0) begin
               checkOutput("inst_pc_load", inst_pc, exp_q[0]);
               checkOutput("pc_next_seq", pc_next, exp_q[0] + 32'd4);
            end
            if (inst_valid) checkOutput("req_while_valid", 32'(imem_req), 32'd0);
            if (prev_valid && !prev_ready && !prev_flush) begin
               checkOutput("hold_valid", 32'(inst_valid), 32'd1);
               checkOutput("hold_pc", inst_pc, prev_ipc);
               checkOutput("hold_data", inst_out, prev_iout);
            end
            if (prev_valid && prev_ready && !prev_flush && exp_q.size() > 0) begin
               checkOutput("next_fetch_req", 32'(imem_req), 32'd1);
               checkOutput("next_fetch_addr", imem_addr, exp_q[0]);
            end
            if (prev_req && !prev_ack) begin
               checkOutput("req_held", 32'(imem_req), 32'd1);
               checkOutput("addr_held", imem_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL transfer: got pc %h, expected nothing pending", inst_pc);
               end else begin
                  exp_pc = exp_q.pop_front();
                  checkOutput("xfer_pc", inst_pc, exp_pc);
                  checkOutput("xfer_data", inst_out, mem_word(exp_pc));
                  exp_q.push_back(exp_pc + 32'd4);
               end
               idle_cycles = 0;
            end else if (flush_now) begin
               idle_cycles = 0;
            end else begin
               idle_cycles++;
               if (idle_cycles >= 64) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL progress: got %0d idle cycles, expected fewer than 64", idle_cycles);
                  idle_cycles = 0;
               end
            end
            prev_valid = inst_valid; prev_ready = inst_ready; prev_flush = flush_now;
            prev_target = tgt_now; prev_req = imem_req; prev_ack = imem_ack;
            prev_addr = imem_addr; prev_ipc = inst_pc; prev_iout = inst_out;
         end
      end
   end

   // Drives one cycle of inputs, then records the predicted fetch target on a flush.
   task automatic applyStimulus(input logic redir, input logic exc, input logic [31:0] tgt, input logic ready);
      redirect_valid  = redir;
      exc_valid       = exc;
      redirect_target = tgt;
      inst_ready      = ready;
      @(negedge clk);
      #1;
      if (redir || exc) begin
         exp_q.delete();
         exp_q.push_back(exc ? EXC_VECTOR : tgt);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic waitCond(input int which, input logic ready);
      bit found;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         case (which)
            COND_REQ_NOACK: found = imem_req && !imem_ack;
            COND_VALID:     found = inst_valid;
            default:        found = imem_req && imem_ack;
         endcase
         if (!found) applyStimulus(1'b0, 1'b0, 32'h0, ready);
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_cond%0d: got timeout, expected condition within 60 cycles", which);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pc_ena"}, 32'(pc_ena), 32'd0);
      checkOutput({tag, "_pc_next"}, pc_next, 32'd0);
      checkOutput({tag, "_imem_req"}, 32'(imem_req), 32'd0);
      checkOutput({tag, "_imem_addr"}, imem_addr, 32'd0);
      checkOutput({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
      checkOutput({tag, "_inst_out"}, inst_out, 32'd0);
      checkOutput({tag, "_inst_pc"}, inst_pc, 32'd0);
   endtask

   initial begin
      logic        r, e;
      logic [31:0] t;
      repeat (2) @(posedge clk);
      #2;
      checkAllZero("reset");
      exp_q.delete();
      exp_q.push_back(RESET_VECTOR);
      rst = 1'b0;

      $display("[TB] sequential fetch from reset vector");
      mem_lat = 0;
      repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] decode stall for five cycles");
      waitCond(COND_VALID, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] redirect during slow fetch");
      mem_lat = 3;
      waitCond(COND_REQ_NOACK, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0040_0100, 1'b1);
      repeat (14) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] exception and redirect together in hold");
      mem_lat = 0;
      waitCond(COND_VALID, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h1234_0000, 1'b0);
      repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] redirect coincident with ack");
      waitCond(COND_REQ_ACK, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0040_0200, 1'b1);
      repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("[TB] address wrap and reset during request");
      applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1);
      repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      mem_lat = 3;
      waitCond(COND_REQ_NOACK, 1'b1);
      rst = 1'b1;
      #1;
      checkAllZero("midreset");
      repeat (3) @(posedge clk);
      #2;
      exp_q.delete();
      exp_q.push_back(RESET_VECTOR);
      rst = 1'b0;

      $display("[TB] randomized traffic");
      mem_lat = -1;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 11) == 0);
         e = ($urandom_range(0, 29) == 0);
         t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         applyStimulus(r, e, t, ($urandom_range(0, 3) != 0));
      end
      repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-side controller at the far end of the PC register interface: reads the current PC, fetches the instruction over a req/ack instruction-memory handshake, and hands it to decode through a valid/ready buffer.
- Drives the PC register's enable and next-value inputs: sequential PC+4, branch/jump redirect, or exception vector.
- Runs on posedge clk. The PC register updates on the following negedge, so a pc_ena pulse is visible on pc_in by the next posedge.

Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value the PC register holds out of reset; used only for bench/consistency checks.
- EXC_VECTOR, 32'h0000_0004, target written to the PC on exc_valid.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset.
- pc_in  in  32  current PC from the PC register.
- pc_ena  out  1  one-cycle write-enable pulse to the PC register.
- pc_next  out  32  next PC value to the PC register.
- imem_req  out  1  instruction-memory request; held until ack.
- imem_addr  out  32  registered fetch address; stable while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  instruction buffer full.
- inst_out  out  32  buffered instruction.
- inst_pc  out  32  address of the buffered instruction.
- inst_ready  in  1  decode accepts the instruction when inst_valid&&inst_ready.
- redirect_valid  in  1  branch/jump taken, single-cycle pulse.
- redirect_target  in  32  redirect PC.
- exc_valid  in  1  exception, single-cycle pulse; priority over redirect.

Behaviour:
- Reset is asynchronous, active-high. While rst: state=SYNC, pc_ena=0, pc_next=0, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0.
- All outputs are registered. imem_req=1 exactly in states FETCH and DRAIN.
- States: SYNC, FETCH, HOLD, DRAIN.
- SYNC: no request. This is the settle cycle that lets the PC register absorb a pc_ena pulse. Next edge: state<=FETCH, imem_addr<=pc_in.
- FETCH: imem_req=1, imem_addr held. On imem_ack:
  - inst_out<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1.
  - pc_ena<=1, pc_next<=imem_addr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - state<=HOLD.
- HOLD: inst_valid=1. On inst_ready: inst_valid<=0, state<=FETCH, imem_addr<=pc_in (the PC has already updated). Minimum residence is one cycle.
- DRAIN: imem_req stays 1 with the same imem_addr; memory requests are never abandoned. On imem_ack: data discarded, state<=SYNC.
- pc_ena is a one-cycle pulse and is 0 in every cycle not listed here.
- Redirect/exception, evaluated in every state. Target = EXC_VECTOR if exc_valid, else redirect_target.
  - pc_ena<=1, pc_next<=target, inst_valid<=0 (the buffered instruction is flushed).
  - FETCH with no ack: state<=DRAIN.
  - FETCH with simultaneous ack: rdata discarded, no buffer load, state<=SYNC.
  - HOLD (with or without inst_ready): state<=SYNC. A same-cycle inst_ready counts as an accepted transfer; the redirect still wins pc_next.
  - SYNC: stay SYNC one more cycle.
  - DRAIN: stay DRAIN, or go SYNC if ack arrives in the same cycle.
- Exception and redirect in the same cycle: only EXC_VECTOR is written.
- Steady-state throughput with 1-cycle ack and inst_ready held high: 1 instruction per 2 cycles (FETCH, HOLD alternating).
- Reset asserted mid-transaction: all state cleared immediately. The memory side must tolerate req dropping without ack.

Test Plan:
1. Reset release, PC=32'h0040_0000, ack one cycle after req, inst_ready=1:
   - Expect imem_addr 00400000, then 00400004, then 00400008.
   - Expect a pc_ena pulse with pc_next 00400004, then 00400008.
   - Expect inst_valid pulses carrying inst_pc matching each fetch address.
2. inst_ready=0 for 5 cycles after first fetch:
   - inst_valid, inst_out, inst_pc held stable; imem_req=0 throughout.
   - No second pc_ena pulse.
   - Next fetch issues the edge after inst_ready rises.
3. redirect_valid (target 32'h0040_0100) during FETCH, ack delayed 3 cycles:
   - pc_ena pulse with pc_next 00400100; imem_addr stays at the old address until ack.
   - Stale data never reaches inst_valid.
   - Next fetch address is 00400100.
4. exc_valid and redirect_valid in the same HOLD cycle, target 32'h1234_0000:
   - pc_next=00000004 only; inst_valid drops.
   - Next fetch address is 00000004.
5. Redirect coincident with imem_ack in FETCH:
   - Buffer not loaded; state goes SYNC, then FETCH at the target.
6. Fetch at 32'hFFFF_FFFC:
   - pc_next=00000000.
   - rst asserted while imem_req=1 clears all outputs within the same cycle.
